// File: rtl/writeback_unit_if.sv
// ---------------------------------------------------------------------------
// writeback_unit_if
// Bundles the instruction-retire handshake, data-memory read return and the
// register-file commit bus used by writeback_unit.
//   slave  : the writeback unit side (takes retire/memory inputs, drives commit)
//   master : the upstream/environment side
// Signals:
//   in_valid / in_ready                      retire handshake
//   RegWrite_in, MemtoReg_in,
//   Write_register_in, ALU_Result_in         retiring instruction fields
//   mem_rdata / mem_rvalid                   data-memory read return
//   RegWrite, MemtoReg, Write_register,
//   data, ALU_Result                         commit bus to the register file
//   busy, load_timeout                       status
// ---------------------------------------------------------------------------
interface writeback_unit_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic              RegWrite_in;
   logic              MemtoReg_in;
   logic [REG_AW-1:0] Write_register_in;
   logic [DATA_W-1:0] ALU_Result_in;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              RegWrite;
   logic              MemtoReg;
   logic [REG_AW-1:0] Write_register;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] ALU_Result;
   logic              busy;
   logic              load_timeout;

   modport slave (
      input  in_valid, RegWrite_in, MemtoReg_in, Write_register_in,
             ALU_Result_in, mem_rdata, mem_rvalid,
      output in_ready, RegWrite, MemtoReg, Write_register, data,
             ALU_Result, busy, load_timeout
   );

   modport master (
      output in_valid, RegWrite_in, MemtoReg_in, Write_register_in,
             ALU_Result_in, mem_rdata, mem_rvalid,
      input  in_ready, RegWrite, MemtoReg, Write_register, data,
             ALU_Result, busy, load_timeout
   );
endinterface

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Writeback stage feeding the register file. Accepts one retiring instruction
// (ALU result or load), waits for load data from a variable-latency memory
// with a bounded wait, then presents a one-cycle registered RegWrite commit.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   wb     writeback_unit_if.slave (retire handshake, memory return, commit bus)
// Optional build macro WB_PERF_CNT_EN adds:
//   retire_count     [31:0] commits plus silent retires
//   mem_stall_count  [31:0] cycles spent waiting on memory
// ---------------------------------------------------------------------------
module writeback_unit #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   writeback_unit_if.slave       wb
`ifdef WB_PERF_CNT_EN
   ,
   output logic [31:0]           retire_count,
   output logic [31:0]           mem_stall_count
`endif
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_MEM,
      COMMIT
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;

   logic silent_retire;
   logic cap_dest;
   logic cap_alu;
   logic cap_load;
   logic cnt_clear;
   logic cnt_inc;
   logic set_timeout;

   // State register; reset drops any pending write on the floor.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and capture-enable decode. A write to r0 is folded into the
   // silent-retire path because r0 can never be written. In WAIT_MEM an rvalid
   // on the final allowed cycle takes priority over abandoning the load.
   always_comb begin
      next_state    = state;
      silent_retire = 1'b0;
      cap_dest      = 1'b0;
      cap_alu       = 1'b0;
      cap_load      = 1'b0;
      cnt_clear     = 1'b0;
      cnt_inc       = 1'b0;
      set_timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (wb.in_valid) begin
               if (!wb.RegWrite_in || (wb.Write_register_in == '0)) begin
                  silent_retire = 1'b1;
               end else if (!wb.MemtoReg_in) begin
                  cap_dest   = 1'b1;
                  cap_alu    = 1'b1;
                  next_state = COMMIT;
               end else if (wb.mem_rvalid) begin
                  cap_dest   = 1'b1;
                  cap_load   = 1'b1;
                  next_state = COMMIT;
               end else begin
                  cap_dest   = 1'b1;
                  cnt_clear  = 1'b1;
                  next_state = WAIT_MEM;
               end
            end
         end
         WAIT_MEM: begin
            if (wb.mem_rvalid) begin
               cap_load   = 1'b1;
               next_state = COMMIT;
            end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
               set_timeout = 1'b1;
               next_state  = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         COMMIT: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Commit bus and status registers. RegWrite is a registered copy of
   // "entering COMMIT", so it is high for exactly the COMMIT cycle and never
   // depends combinationally on inputs. The other commit fields only change on
   // capture so they hold between commits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb.RegWrite       <= 1'b0;
         wb.MemtoReg       <= 1'b0;
         wb.Write_register <= '0;
         wb.data           <= '0;
         wb.ALU_Result     <= '0;
         wb.load_timeout   <= 1'b0;
         wait_cnt          <= '0;
      end else begin
         wb.RegWrite <= (next_state == COMMIT);
         if (cap_dest) begin
            wb.Write_register <= wb.Write_register_in;
            wb.MemtoReg       <= wb.MemtoReg_in;
         end
         if (cap_alu) begin
            wb.ALU_Result <= wb.ALU_Result_in;
         end
         if (cap_load) begin
            wb.data <= wb.mem_rdata;
         end
         if (set_timeout) begin
            wb.load_timeout <= 1'b1;
         end
         if (cnt_clear) begin
            wait_cnt <= '0;
         end else if (cnt_inc) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   // Handshake and status are pure decodes of the state register.
   always_comb begin
      wb.in_ready = (state == IDLE);
      wb.busy     = (state != IDLE);
   end

`ifdef WB_PERF_CNT_EN
   // Free-running performance counters, wrapping naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_count    <= '0;
         mem_stall_count <= '0;
      end else begin
         if ((state == COMMIT) || silent_retire) begin
            retire_count <= retire_count + 32'd1;
         end
         if (state == WAIT_MEM) begin
            mem_stall_count <= mem_stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
// Self-checking bench for writeback_unit. Expected commits are queued when the
// stimulus that should cause them is driven; a negedge monitor pops and
// compares on every RegWrite pulse. Directed checks cover handshake timing,
// holding of outputs, r0 suppression, timeout and asynchronous reset.
// Define WB_PERF_CNT_EN to also exercise the performance counters.
// ---------------------------------------------------------------------------
module tb_writeback_unit;

   localparam int DATA_W      = 32;
   localparam int REG_AW      = 5;
   localparam int MEM_TIMEOUT = 15;

   typedef struct packed {
      logic              mtr;
      logic [REG_AW-1:0] wr;
      logic [DATA_W-1:0] value;
   } commit_t;

   logic clk;
   logic reset;
   int   check_count;
   int   error_count;
   commit_t exp_q[$];
   commit_t exp_item;
   logic [DATA_W-1:0] last_alu;
   logic [DATA_W-1:0] last_data;

`ifdef WB_PERF_CNT_EN
   logic [31:0] retire_count;
   logic [31:0] mem_stall_count;
`endif

   writeback_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) wb ();

   writeback_unit #(
      .DATA_W(DATA_W),
      .REG_AW(REG_AW),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wb(wb)
`ifdef WB_PERF_CNT_EN
      ,
      .retire_count(retire_count),
      .mem_stall_count(mem_stall_count)
`endif
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Moves to just after the next rising edge so inputs change away from it.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic rw,
                                input logic mtr, input logic [REG_AW-1:0] wr,
                                input logic [DATA_W-1:0] alu,
                                input logic rvalid,
                                input logic [DATA_W-1:0] rdata);
      wb.in_valid          = valid;
      wb.RegWrite_in       = rw;
      wb.MemtoReg_in       = mtr;
      wb.Write_register_in = wr;
      wb.ALU_Result_in     = alu;
      wb.mem_rvalid        = rvalid;
      wb.mem_rdata         = rdata;
   endtask

   task automatic pushExpected(input logic mtr, input logic [REG_AW-1:0] wr,
                               input logic [DATA_W-1:0] value);
      commit_t c;
      c.mtr   = mtr;
      c.wr    = wr;
      c.value = value;
      exp_q.push_back(c);
   endtask

   task automatic doAlu(input logic [REG_AW-1:0] wr, input logic [DATA_W-1:0] val);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, wr, val, 1'b0, 32'h0);
      pushExpected(1'b0, wr, val);
      last_alu = val;
      @(negedge clk);
      checkOutput("alu_accept_ready", 64'(wb.in_ready), 64'd1);
      checkOutput("alu_no_early_write", 64'(wb.RegWrite), 64'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("alu_commit_strobe", 64'(wb.RegWrite), 64'd1);
      checkOutput("alu_commit_not_ready", 64'(wb.in_ready), 64'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("alu_strobe_single", 64'(wb.RegWrite), 64'd0);
      checkOutput("alu_ready_again", 64'(wb.in_ready), 64'd1);
      checkOutput("alu_result_hold", 64'(wb.ALU_Result), 64'(val));
   endtask

   // lat = number of WAIT_MEM cycles up to and including the rvalid cycle;
   // lat = 0 means rvalid arrives in the accept cycle.
   task automatic doLoad(input logic [REG_AW-1:0] wr, input int lat,
                         input logic [DATA_W-1:0] rd);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, wr, 32'h5A5A5A5A, (lat == 0), rd);
      if (lat == 0) pushExpected(1'b1, wr, rd);
      @(negedge clk);
      checkOutput("load_accept_idle", 64'(wb.busy), 64'd0);
      for (int i = 1; i <= lat; i++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, (i == lat), rd);
         if (i == lat) pushExpected(1'b1, wr, rd);
         @(negedge clk);
         checkOutput("load_wait_busy", 64'(wb.busy), 64'd1);
         checkOutput("load_wait_no_write", 64'(wb.RegWrite), 64'd0);
      end
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      last_data = rd;
      @(negedge clk);
      checkOutput("load_commit_strobe", 64'(wb.RegWrite), 64'd1);
      checkOutput("load_commit_busy", 64'(wb.busy), 64'd1);
      checkOutput("load_alu_hold", 64'(wb.ALU_Result), 64'(last_alu));
      nextCycle();
      @(negedge clk);
      checkOutput("load_done_idle", 64'(wb.busy), 64'd0);
      checkOutput("load_data_hold", 64'(wb.data), 64'(rd));
   endtask

   task automatic doSilent(input logic rw, input logic [REG_AW-1:0] wr);
      nextCycle();
      applyStimulus(1'b1, rw, 1'b0, wr, 32'hFFFF0000, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("silent_accept_ready", 64'(wb.in_ready), 64'd1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("silent_no_write", 64'(wb.RegWrite), 64'd0);
      checkOutput("silent_still_ready", 64'(wb.in_ready), 64'd1);
      checkOutput("silent_alu_hold", 64'(wb.ALU_Result), 64'(last_alu));
      checkOutput("silent_data_hold", 64'(wb.data), 64'(last_data));
   endtask

   task automatic doTimeout(input logic [REG_AW-1:0] wr);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, wr, 32'h0, 1'b0, 32'h0);
      for (int i = 1; i <= MEM_TIMEOUT; i++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput("timeout_wait_busy", 64'(wb.busy), 64'd1);
         checkOutput("timeout_not_yet", 64'(wb.load_timeout), 64'd0);
      end
      nextCycle();
      @(negedge clk);
      checkOutput("timeout_idle", 64'(wb.busy), 64'd0);
      checkOutput("timeout_flag", 64'(wb.load_timeout), 64'd1);
      checkOutput("timeout_no_write", 64'(wb.RegWrite), 64'd0);
   endtask

   // Every commit strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && (wb.RegWrite === 1'b1)) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_commit", 64'd1, 64'd0);
         end else begin
            exp_item = exp_q.pop_front();
            checkOutput("commit_wr", 64'(wb.Write_register), 64'(exp_item.wr));
            checkOutput("commit_mtr", 64'(wb.MemtoReg), 64'(exp_item.mtr));
            if (exp_item.mtr)
               checkOutput("commit_data", 64'(wb.data), 64'(exp_item.value));
            else
               checkOutput("commit_alu", 64'(wb.ALU_Result), 64'(exp_item.value));
         end
      end
   end

   initial begin
      check_count = 0;
      error_count = 0;
      last_alu    = '0;
      last_data   = '0;
      reset       = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      #1 reset = 1'b1;
      #2;
      $display("[TB] reset values");
      checkOutput("rst_regwrite", 64'(wb.RegWrite), 64'd0);
      checkOutput("rst_wr", 64'(wb.Write_register), 64'd0);
      checkOutput("rst_data", 64'(wb.data), 64'd0);
      checkOutput("rst_alu", 64'(wb.ALU_Result), 64'd0);
      checkOutput("rst_timeout", 64'(wb.load_timeout), 64'd0);
      checkOutput("rst_ready", 64'(wb.in_ready), 64'd1);
      checkOutput("rst_busy", 64'(wb.busy), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      $display("[TB] ALU write, 3-cycle load, silent retire");
      doAlu(5'd5, 32'h0000002A);
      doLoad(5'd9, 3, 32'hDEADBEEF);
      doSilent(1'b0, 5'd7);
`ifdef WB_PERF_CNT_EN
      checkOutput("perf_retire", 64'(retire_count), 64'd3);
      checkOutput("perf_stall", 64'(mem_stall_count), 64'd3);
`endif

      $display("[TB] zero-latency load and r0 suppression");
      doLoad(5'd3, 0, 32'h12345678);
      doSilent(1'b1, 5'd0);
      doAlu(5'd31, 32'hFFFFFFFF);

      $display("[TB] load timeout and rvalid on final cycle");
      doTimeout(5'd4);
      doLoad(5'd6, MEM_TIMEOUT, 32'hCAFEF00D);
      checkOutput("timeout_sticky", 64'(wb.load_timeout), 64'd1);

      $display("[TB] reset during WAIT_MEM");
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 5'd10, 32'h0, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      nextCycle();
      #2 reset = 1'b1;
      #1;
      checkOutput("midrst_regwrite", 64'(wb.RegWrite), 64'd0);
      checkOutput("midrst_mtr", 64'(wb.MemtoReg), 64'd0);
      checkOutput("midrst_wr", 64'(wb.Write_register), 64'd0);
      checkOutput("midrst_data", 64'(wb.data), 64'd0);
      checkOutput("midrst_alu", 64'(wb.ALU_Result), 64'd0);
      checkOutput("midrst_timeout", 64'(wb.load_timeout), 64'd0);
      checkOutput("midrst_ready", 64'(wb.in_ready), 64'd1);
      checkOutput("midrst_busy", 64'(wb.busy), 64'd0);
`ifdef WB_PERF_CNT_EN
      checkOutput("midrst_perf_retire", 64'(retire_count), 64'd0);
      checkOutput("midrst_perf_stall", 64'(mem_stall_count), 64'd0);
`endif
      nextCycle();
      reset = 1'b0;
      last_alu  = '0;
      last_data = '0;
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h77777777);
         @(negedge clk);
         checkOutput("postrst_no_write", 64'(wb.RegWrite), 64'd0);
         checkOutput("postrst_ready", 64'(wb.in_ready), 64'd1);
      end
      checkOutput("postrst_data_ignored", 64'(wb.data), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      doAlu(5'd12, 32'h0BADF00D);

      nextCycle();
      nextCycle();
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage directly upstream of the register-file / operand-preparation stage.
- Accepts a retiring instruction (ALU result or load), waits for load data when required, then drives RegWrite, MemtoReg, destination register and the data/ALU_Result buses for exactly one commit cycle.
- Serialises loads against a variable-latency data memory, with a bounded wait.

Parameters:
- DATA_W, 32, width of ALU result and memory data.
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 15, max cycles spent in WAIT_MEM before the load is abandoned.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a retiring instruction.
- in_ready  output  1  unit can accept this cycle.
- RegWrite_in  input  1  instruction writes a register.
- MemtoReg_in  input  1  1 = load (data from memory), 0 = ALU result.
- Write_register_in  input  REG_AW  destination register.
- ALU_Result_in  input  DATA_W  ALU result.
- mem_rdata  input  DATA_W  data-memory read data.
- mem_rvalid  input  1  mem_rdata valid this cycle.
- RegWrite  output  1  one-cycle commit strobe to the register file.
- MemtoReg  output  1  source select for the commit.
- Write_register  output  REG_AW  destination of the commit.
- data  output  DATA_W  captured load data.
- ALU_Result  output  DATA_W  captured ALU result.
- busy  output  1  state != IDLE.
- load_timeout  output  1  sticky; set when a load is abandoned.

Behaviour:
- Reset values (asynchronous clear): state IDLE, RegWrite 0, MemtoReg 0, Write_register 0, data 0, ALU_Result 0, load_timeout 0, wait counter 0. in_ready is 1 after reset.
- FSM states: IDLE, WAIT_MEM, COMMIT.
- in_ready = (state == IDLE). Accept occurs on in_valid & in_ready.
- IDLE, accept:
  - RegWrite_in = 0: instruction retired silently; stay IDLE; no output change.
  - Write_register_in = 0: treat as RegWrite_in = 0, because r0 is never written.
  - MemtoReg_in = 0: capture ALU_Result_in, Write_register_in and MemtoReg; go to COMMIT.
  - MemtoReg_in = 1 and mem_rvalid in the same cycle: capture mem_rdata into data; go to COMMIT.
  - MemtoReg_in = 1 without mem_rvalid: capture destination and MemtoReg; clear counter; go to WAIT_MEM.
- WAIT_MEM:
  - On mem_rvalid: capture mem_rdata; go to COMMIT.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 without rvalid: set load_timeout, go to IDLE, no commit.
  - mem_rvalid arriving on the timeout cycle wins: the commit proceeds.
- COMMIT: RegWrite = 1 for exactly this one cycle; next state IDLE. RegWrite is registered, never combinational from inputs.
- mem_rvalid while in IDLE or COMMIT: ignored.
- Latency: ALU op accepted in cycle N gives RegWrite high in cycle N+1. A load gives RegWrite high in the cycle after the rvalid capture.
- Throughput: one instruction per 2 cycles at best (no accept during COMMIT).
- Outputs data, ALU_Result, Write_register and MemtoReg hold their last values outside COMMIT.
- load_timeout is cleared only by reset.
- Reset mid-operation (WAIT_MEM or COMMIT): pending write discarded, no RegWrite pulse, outputs cleared immediately.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- When defined:
  - Adds output retire_count (32 bits): increments on every COMMIT cycle and on every silent retire.
  - Adds output mem_stall_count (32 bits): increments on every WAIT_MEM cycle.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- ALU write: accept RegWrite_in=1, MemtoReg_in=0, Write_register_in=5, ALU_Result_in=0x0000002A in cycle N -> RegWrite=1, Write_register=5, ALU_Result=0x2A in N+1 only; in_ready=1 at N+2.
- Load, 3-cycle memory: accept load to r9 in N, mem_rvalid in N+3 with rdata=0xDEADBEEF -> busy N+1..N+4, RegWrite=1 in N+4 with data=0xDEADBEEF, MemtoReg=1.
- Zero-latency load plus r0 suppression: load to r3 with rvalid at acceptance -> commit next cycle. Then accept RegWrite_in=1 to r0 -> no RegWrite, in_ready stays 1.
- Timeout: load accepted, mem_rvalid never asserted, MEM_TIMEOUT=15 -> load_timeout=1 after 15 WAIT_MEM cycles, no RegWrite, IDLE. Then mem_rvalid exactly on the 15th cycle in a second run -> commit occurs.
- Reset mid-WAIT_MEM: assert reset asynchronously, mid-cycle -> all outputs 0 immediately, no RegWrite pulse after release, in_ready=1.
- With WB_PERF_CNT_EN: ALU op, 3-cycle load, and one silent retire -> retire_count=3, mem_stall_count=3.
